simon_fsm_gen: RTL and testbench

Parametrised successor to the fixed-pattern Simon controller.
- Generates a pseudo-random sequence of length MAX_LEN from a 16-bit LFSR at game start, over NUM_CH colour channels.
- Plays back a growing prefix of the sequence with an LED on-time plus an inter-LED gap, then checks player presses.
- Reports round and win/error status.
- Sits between the button debouncer/one-shot (btn_clk domain) and the LED and seven-segment drivers.

---
 rtl/simon_pkg.sv | 30 +++
 rtl/simon_fsm_gen_if.sv | 32 +++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_fsm_gen.sv | 183 ++++++++++++++++++
 tb/tb_simon_fsm_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared constants for the generated-sequence Simon controller: state codes,
// LFSR taps and the width helpers used by the interface and the RTL.
package simon_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GEN      = 3'd1;
  localparam logic [2:0] S_PLAY_ON  = 3'd2;
  localparam logic [2:0] S_PLAY_OFF = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;
  localparam logic [2:0] S_WIN      = 3'd7;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Never returns less than 1 so single-value ranges still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_fsm_gen_if.sv
// Player/display side bus of the Simon controller; the FSM uses the slave
// modport, whoever drives buttons and watches LEDs uses the master modport.
interface simon_fsm_gen_if
  import simon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 16
);

  localparam int CW = clog2(NUM_CH);
  localparam int IW = clog2(MAX_LEN + 1);

  logic              start;
  logic              btn_valid;
  logic [CW-1:0]     btn_val;
  logic [NUM_CH-1:0] led;
  logic              error_led;
  logic              win_led;
  logic [IW-1:0]     round_out;
  logic [2:0]        state;

  modport master (
    output start, btn_valid, btn_val,
    input  led, error_led, win_led, round_out, state
  );

  modport slave (
    input  start, btn_valid, btn_val,
    output led, error_led, win_led, round_out, state
  );

endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR (right-shifting, taps applied when the
// outgoing bit is 1); steps on every clk_tick edge.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clk_tick,
  input  logic        reset_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? TAPS : 16'h0000);
  end

  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) q_q <= SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/simon_fsm_gen.sv
// Simon game controller: draws a random sequence at game start, replays a
// growing prefix and checks presses. Optional macro: INPUT_TIMEOUT_EN.
module simon_fsm_gen
  import simon_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          MAX_LEN  = 16,
  parameter int          LED_HOLD = 96,
  parameter int          LED_GAP  = 16,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          TIMEOUT  = 500
) (
  input logic            clk_tick,
  input logic            reset_n,
  simon_fsm_gen_if.slave bus
);

  localparam int CW = clog2(NUM_CH);
  localparam int IW = clog2(MAX_LEN + 1);
  localparam int AW = clog2(MAX_LEN);
  localparam int TW = clog2(max3(LED_HOLD, LED_GAP, TIMEOUT));

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] gen_idx_q, gen_idx_d;
  logic [AW-1:0] play_idx_q, play_idx_d;
  logic [AW-1:0] input_idx_q, input_idx_d;
  logic [IW-1:0] round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] btn_q, btn_d;
  logic          gap_first_q, gap_first_d;
  logic [CW-1:0] seq_q [MAX_LEN];
  logic          seq_we;
  logic [15:0]   lfsr_q;
  logic [IW-1:0] play_next;
  logic [IW-1:0] input_next;

  simon_lfsr #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk_tick (clk_tick),
    .reset_n  (reset_n),
    .q        (lfsr_q)
  );

  assign play_next  = IW'(play_idx_q) + IW'(1);
  assign input_next = IW'(input_idx_q) + IW'(1);

  // gap_first marks the dark gap between a completed round and its replay,
  // after which playback restarts at index 0 instead of advancing.
  always_comb begin
    state_d     = state_q;
    gen_idx_d   = gen_idx_q;
    play_idx_d  = play_idx_q;
    input_idx_d = input_idx_q;
    round_d     = round_q;
    timer_d     = timer_q;
    btn_d       = btn_q;
    gap_first_d = gap_first_q;
    seq_we      = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR, S_WIN: begin
        if (bus.start) begin
          gen_idx_d = '0;
          state_d   = S_GEN;
        end
      end

      S_GEN: begin
        seq_we = 1'b1;
        if (gen_idx_q == AW'(MAX_LEN - 1)) begin
          round_d     = IW'(1);
          play_idx_d  = '0;
          timer_d     = '0;
          gap_first_d = 1'b0;
          state_d     = S_PLAY_ON;
        end else begin
          gen_idx_d = gen_idx_q + AW'(1);
        end
      end

      S_PLAY_ON: begin
        if (timer_q == TW'(LED_HOLD - 1)) begin
          timer_d = '0;
          state_d = S_PLAY_OFF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_PLAY_OFF: begin
        if (timer_q == TW'(LED_GAP - 1)) begin
          timer_d = '0;
          if (gap_first_q) begin
            gap_first_d = 1'b0;
            state_d     = S_PLAY_ON;
          end else if (play_next < round_q) begin
            play_idx_d = AW'(play_next);
            state_d    = S_PLAY_ON;
          end else begin
            input_idx_d = '0;
            state_d     = S_WAIT;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT: begin
        if (bus.btn_valid) begin
          btn_d   = bus.btn_val;
          state_d = S_CHECK;
        end
`ifdef INPUT_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end

      S_CHECK: begin
        if (btn_q != seq_q[input_idx_q]) begin
          state_d = S_ERROR;
        end else if (input_next < round_q) begin
          input_idx_d = AW'(input_next);
          timer_d     = '0;
          state_d     = S_WAIT;
        end else if (round_q != IW'(MAX_LEN)) begin
          round_d     = round_q + IW'(1);
          play_idx_d  = '0;
          timer_d     = '0;
          gap_first_d = 1'b1;
          state_d     = S_PLAY_OFF;
        end else begin
          state_d = S_WIN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gen_idx_q   <= '0;
      play_idx_q  <= '0;
      input_idx_q <= '0;
      round_q     <= '0;
      timer_q     <= '0;
      btn_q       <= '0;
      gap_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_idx_q   <= gen_idx_d;
      play_idx_q  <= play_idx_d;
      input_idx_q <= input_idx_d;
      round_q     <= round_d;
      timer_q     <= timer_d;
      btn_q       <= btn_d;
      gap_first_q <= gap_first_d;
    end
  end

  always_ff @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
    end else if (seq_we) begin
      seq_q[gen_idx_q] <= lfsr_q[CW-1:0];
    end
  end

  // Outputs decode straight from state so an async reset darkens them at once.
  assign bus.led       = (state_q == S_PLAY_ON) ? (NUM_CH'(1) << seq_q[play_idx_q]) : '0;
  assign bus.error_led = (state_q == S_ERROR);
  assign bus.win_led   = (state_q == S_WIN);
  assign bus.round_out = round_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_simon_fsm_gen.sv
// Directed self-checking bench for simon_fsm_gen (MAX_LEN=4); exercises the
// INPUT_TIMEOUT_EN behaviour when that macro is defined.
module tb_simon_fsm_gen;

  localparam int          NUM_CH   = 4;
  localparam int          MAX_LEN  = 4;
  localparam int          LED_HOLD = 96;
  localparam int          LED_GAP  = 16;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          TIMEOUT  = 10;

  localparam logic [2:0] stIdle    = 3'd0;
  localparam logic [2:0] stGen     = 3'd1;
  localparam logic [2:0] stPlayOn  = 3'd2;
  localparam logic [2:0] stPlayOff = 3'd3;
  localparam logic [2:0] stWait    = 3'd4;
  localparam logic [2:0] stCheck   = 3'd5;
  localparam logic [2:0] stError   = 3'd6;
  localparam logic [2:0] stWin     = 3'd7;

  logic        clk_tick;
  logic        reset_n;
  logic [15:0] modelLfsr;
  int          expSeq [MAX_LEN];
  int          numChecks;
  int          numFails;

  simon_fsm_gen_if #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN)) bus ();

  simon_fsm_gen #(
    .NUM_CH   (NUM_CH),
    .MAX_LEN  (MAX_LEN),
    .LED_HOLD (LED_HOLD),
    .LED_GAP  (LED_GAP),
    .SEED     (SEED),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_tick (clk_tick),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk_tick = 1'b0;
  always #5 clk_tick = ~clk_tick;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: same polynomial, stepping on every clock edge.
  always @(posedge clk_tick or negedge reset_n) begin
    if (!reset_n) modelLfsr <= SEED;
    else          modelLfsr <= lfsrStep(modelLfsr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic startIn, input logic validIn, input logic [1:0] valIn);
    bus.start     = startIn;
    bus.btn_valid = validIn;
    bus.btn_val   = valIn;
    @(negedge clk_tick);
    bus.start     = 1'b0;
    bus.btn_valid = 1'b0;
  endtask

  // Entered on the first S_GEN cycle; records the value each entry captures.
  task automatic runGen(input string tag);
    int genOk;
    genOk = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bus.state == stGen) genOk++;
      expSeq[i] = int'(modelLfsr[1:0]);
      @(negedge clk_tick);
    end
    checkOutput({tag, "GenCycles"}, genOk, MAX_LEN);
    checkOutput({tag, "PlayOn"}, bus.state, stPlayOn);
    checkOutput({tag, "Round1"}, bus.round_out, 1);
  endtask

  task automatic checkPlayback(input int n, input bit gapFirst, input bit inject, input string tag);
    int onGood;
    int offGood;
    logic [3:0] expLed;
    onGood  = 0;
    offGood = 0;
    if (gapFirst) begin
      for (int c = 0; c < LED_GAP; c++) begin
        bus.btn_valid = inject && (c == 7);
        if (bus.state == stPlayOff && bus.led == 4'b0000) offGood++;
        @(negedge clk_tick);
      end
    end
    for (int i = 0; i < n; i++) begin
      expLed = 4'(1 << expSeq[i]);
      for (int c = 0; c < LED_HOLD; c++) begin
        bus.btn_valid = inject && (c % 9 == 4);
        bus.btn_val   = 2'(c);
        if (bus.state == stPlayOn && bus.led == expLed) onGood++;
        @(negedge clk_tick);
      end
      for (int c = 0; c < LED_GAP; c++) begin
        bus.btn_valid = inject && (c == 7);
        if (bus.state == stPlayOff && bus.led == 4'b0000) offGood++;
        @(negedge clk_tick);
      end
    end
    bus.btn_valid = 1'b0;
    checkOutput({tag, "OnCycles"}, onGood, n * LED_HOLD);
    checkOutput({tag, "OffCycles"}, offGood, (n + int'(gapFirst)) * LED_GAP);
    checkOutput({tag, "Wait"}, bus.state, stWait);
  endtask

  task automatic playRound(input int r, input int wrongAt, input string tag);
    for (int j = 0; j < r; j++) begin
      logic [1:0] v;
      v = 2'(expSeq[j]);
      if (j == wrongAt) v = v ^ 2'b01;
      applyStimulus(1'b0, 1'b1, v);
      checkOutput({tag, "Check"}, bus.state, stCheck);
      @(negedge clk_tick);
      if (j == wrongAt) return;
      if (j < r - 1) checkOutput({tag, "NextWait"}, bus.state, stWait);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, failures so far %0d", numFails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    numChecks     = 0;
    numFails      = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_val   = 2'd0;
    repeat (3) @(negedge clk_tick);
    checkOutput("rstState", bus.state, stIdle);
    checkOutput("rstLed", bus.led, 0);
    checkOutput("rstRound", bus.round_out, 0);
    checkOutput("rstFlags", {bus.error_led, bus.win_led}, 0);
    reset_n = 1'b1;
    @(negedge clk_tick);
    checkOutput("idleHold", bus.state, stIdle);

    // Game 1: full correct play to a win
    applyStimulus(1'b1, 1'b0, 2'd0);
    runGen("g1");
    checkOutput("g1FirstLed", bus.led, 4'b0001);
    for (int r = 1; r <= MAX_LEN; r++) begin
      checkOutput("g1Round", bus.round_out, r);
      checkPlayback(r, r > 1, r == 1, "g1");
      if (r == 1) begin
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("startInWait", bus.state, stWait);
      end
      playRound(r, -1, "g1");
      if (r < MAX_LEN) begin
        checkOutput("g1GapFirst", bus.state, stPlayOff);
        checkOutput("g1RoundUp", bus.round_out, r + 1);
      end
    end
    checkOutput("winState", bus.state, stWin);
    checkOutput("winLed", bus.win_led, 1);
    repeat (20) @(negedge clk_tick);
    checkOutput("noReplay", {bus.state, bus.led}, {stWin, 4'b0000});

    // Game 2: wrong second press in round 3
    applyStimulus(1'b1, 1'b0, 2'd0);
    runGen("g2");
    for (int r = 1; r <= 3; r++) begin
      checkPlayback(r, r > 1, 1'b0, "g2");
      playRound(r, (r == 3) ? 1 : -1, "g2");
    end
    checkOutput("errState", bus.state, stError);
    checkOutput("errLed", bus.error_led, 1);
    checkOutput("errRound", bus.round_out, 3);
    applyStimulus(1'b0, 1'b1, 2'(expSeq[0]));
    checkOutput("errIgnoresBtn", bus.state, stError);
    applyStimulus(1'b1, 1'b1, 2'd0);
    checkOutput("startWinsInErr", bus.state, stGen);
    runGen("g3");

    // Async reset during S_PLAY_ON, checked before the next clock edge
    repeat (10) @(negedge clk_tick);
    checkOutput("preRstOn", bus.state, stPlayOn);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncRstState", bus.state, stIdle);
    checkOutput("asyncRstLed", bus.led, 0);
    checkOutput("asyncRstRound", bus.round_out, 0);
    checkOutput("asyncRstLfsr", dut.lfsr_q, 16'hACE1);
    @(negedge clk_tick);
    reset_n = 1'b1;
    @(negedge clk_tick);

    // Behaviour while waiting for a press that never comes
    applyStimulus(1'b1, 1'b0, 2'd0);
    runGen("g4");
    checkPlayback(1, 1'b0, 1'b0, "g4");
`ifdef INPUT_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge clk_tick);
    checkOutput("tmoStillWait", bus.state, stWait);
    @(negedge clk_tick);
    checkOutput("tmoError", bus.state, stError);
    applyStimulus(1'b1, 1'b0, 2'd0);
    runGen("g5");
    checkPlayback(1, 1'b0, 1'b0, "g5");
    repeat (TIMEOUT - 1) @(negedge clk_tick);
    applyStimulus(1'b0, 1'b1, 2'(expSeq[0]));
    checkOutput("tmoPressWins", bus.state, stCheck);
`else
    repeat (1000) @(negedge clk_tick);
    checkOutput("noTimeout", bus.state, stWait);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
